// File: rtl/qed_dup_sequencer_pkg.sv
// Shared types for the SQED duplicate-stream sequencer.
// Optional feature macro: QED_AUTO_SWITCH_EN.
package qed_pkg;

  typedef enum logic [1:0] {
    QED_IDLE = 2'd0,
    QED_ORIG = 2'd1,
    QED_DUP  = 2'd2,
    QED_WAIT = 2'd3
  } qed_state_e;

  localparam int QED_INSN_W = 32;
  localparam int QED_CNT_W  = 16;
  localparam int QED_DEPTH  = 16;

endpackage

// File: rtl/qed_dup_sequencer_if.sv
// Fetch/issue/retire bundle between the core front end and the sequencer.
// master drives core-side inputs; slave is the sequencer.
interface qed_dup_sequencer_if
  import qed_pkg::*;
#(
  parameter int INSN_W = QED_INSN_W,
  parameter int CNT_W  = QED_CNT_W
);
  logic              qed_ena;
  logic              exec_dup;
  logic              fetch_valid;
  logic [INSN_W-1:0] fetch_insn;
  logic              fetch_ready;
  logic              issue_valid;
  logic [INSN_W-1:0] issue_insn;
  logic              issue_is_dup;
  logic              issue_ready;
  logic              orig_retire;
  logic              dup_retire;
  logic [CNT_W-1:0]  qed_num_orig;
  logic [CNT_W-1:0]  qed_num_dup;
  logic              qed_ready;
  logic [1:0]        sif_state;

  modport master (
    output qed_ena, exec_dup,
    output fetch_valid, fetch_insn,
    output issue_ready,
    output orig_retire, dup_retire,
    input  fetch_ready,
    input  issue_valid, issue_insn,
    input  issue_is_dup,
    input  qed_num_orig, qed_num_dup,
    input  qed_ready, sif_state
  );

  modport slave (
    input  qed_ena, exec_dup,
    input  fetch_valid, fetch_insn,
    input  issue_ready,
    input  orig_retire, dup_retire,
    output fetch_ready,
    output issue_valid, issue_insn,
    output issue_is_dup,
    output qed_num_orig, qed_num_dup,
    output qed_ready, sif_state
  );
endinterface

// File: rtl/qed_dup_sequencer_insn_cache.sv
// Instruction cache FIFO recording the original stream for replay.
// Pointers carry one wrap bit to tell full from empty.
module qed_insn_cache #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         one_left,
  output logic         last_slot
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  used;
  logic [W-1:0] mem [DEPTH];

  assign used      = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign one_left  = (used == (AW+1)'(1));
  assign last_slot = (used == (AW+1)'(DEPTH-1));
  assign head      = mem[rd_ptr[AW-1:0]];

  // Pointer update; push on full / pop on empty never requested.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/qed_dup_sequencer.sv
// SQED sequencer: passes/records originals, replays duplicates, checks retire counts.
// Macro QED_AUTO_SWITCH_EN: a push filling the cache forces ORIG->DUP.
module qed_dup_sequencer
  import qed_pkg::*;
#(
  parameter int DEPTH  = QED_DEPTH,
  parameter int INSN_W = QED_INSN_W,
  parameter int CNT_W  = QED_CNT_W
) (
  input logic               clk,
  input logic               resetn,
  qed_dup_sequencer_if.slave sif
);
  qed_state_e        state;
  logic [CNT_W-1:0]  num_orig;
  logic [CNT_W-1:0]  num_dup;

  logic              full;
  logic              empty;
  logic              one_left;
  logic              last_slot;
  logic [INSN_W-1:0] head;

  logic              push;
  logic              pop;
  logic              iv;
  logic              fr;
  logic              dup;
  logic              qrdy;
  logic [INSN_W-1:0] insn;

  qed_insn_cache #(
    .DEPTH (DEPTH),
    .W     (INSN_W)
  ) u_cache (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .din       (sif.fetch_insn),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .one_left  (one_left),
    .last_slot (last_slot)
  );

  // Per-state muxing of the fetch/issue handshake.
  always_comb begin
    iv   = 1'b0;
    fr   = 1'b0;
    dup  = 1'b0;
    qrdy = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    insn = '0;
    unique case (state)
      QED_IDLE: begin
        iv   = sif.fetch_valid;
        fr   = sif.issue_ready;
        insn = sif.fetch_insn;
      end
      QED_ORIG: begin
        iv   = sif.fetch_valid && !full;
        fr   = sif.issue_ready && !full;
        insn = sif.fetch_insn;
        push = sif.fetch_valid && fr;
      end
      QED_DUP: begin
        iv   = !empty;
        dup  = 1'b1;
        insn = head;
        pop  = !empty && sif.issue_ready;
      end
      QED_WAIT: begin
        qrdy = (num_orig == num_dup);
      end
      default: ;
    endcase
  end

  assign sif.issue_valid  = resetn && iv;
  assign sif.fetch_ready  = resetn && fr;
  assign sif.issue_is_dup = resetn && dup;
  assign sif.qed_ready    = resetn && qrdy;
  assign sif.issue_insn   = resetn ? insn : '0;
  assign sif.sif_state    = state;
  assign sif.qed_num_orig = num_orig;
  assign sif.qed_num_dup  = num_dup;

  // Phase FSM: IDLE -> ORIG -> DUP -> WAIT -> ORIG/IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= QED_IDLE;
    end else begin
      unique case (state)
        QED_IDLE: begin
          if (sif.qed_ena) state <= QED_ORIG;
        end
        QED_ORIG: begin
          if (sif.exec_dup && !empty)
            state <= QED_DUP;
`ifdef QED_AUTO_SWITCH_EN
          else if (push && last_slot)
            state <= QED_DUP;
`endif
          else if (!sif.qed_ena && empty)
            state <= QED_IDLE;
        end
        QED_DUP: begin
          if (pop && one_left) state <= QED_WAIT;
        end
        QED_WAIT: begin
          if (qrdy)
            state <= sif.qed_ena ? QED_ORIG : QED_IDLE;
        end
        default: state <= QED_IDLE;
      endcase
    end
  end

  // Retirement counters, free-running and wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      num_orig <= '0;
      num_dup  <= '0;
    end else begin
      if (sif.orig_retire) num_orig <= num_orig + 1'b1;
      if (sif.dup_retire)  num_dup  <= num_dup + 1'b1;
    end
  end
endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Self-checking bench for qed_dup_sequencer.
// Honours QED_AUTO_SWITCH_EN the same way as the design.
module tb_qed_dup_sequencer;
  import qed_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  qed_dup_sequencer_if sif ();

  qed_dup_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .sif    (sif)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        fv;
    logic [31:0] insn;
    logic        ir;
    logic        exp_iv;
    logic        exp_fr;
    logic [31:0] exp_insn;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    sif.qed_ena     = 1'b0;
    sif.exec_dup    = 1'b0;
    sif.fetch_valid = 1'b0;
    sif.fetch_insn  = '0;
    sif.issue_ready = 1'b0;
    sif.orig_retire = 1'b0;
    sif.dup_retire  = 1'b0;
  endtask

  task automatic orig_push(logic [31:0] w);
    sif.fetch_valid = 1'b1;
    sif.fetch_insn  = w;
    sif.issue_ready = 1'b1;
    #1;
    chk("orig_fetch_ready", sif.fetch_ready, 1);
    chk("orig_issue_valid", sif.issue_valid, 1);
    chk("orig_issue_insn", sif.issue_insn, w);
    chk("orig_is_dup", sif.issue_is_dup, 0);
    exp_q.push_back(w);
    tick();
    sif.fetch_valid = 1'b0;
    sif.issue_ready = 1'b0;
  endtask

  task automatic to_dup();
    sif.exec_dup = 1'b1;
    tick();
    sif.exec_dup = 1'b0;
    #1;
    chk("enter_dup", sif.sif_state, QED_DUP);
  endtask

  task automatic drain(int budget);
    bit done;
    done = 0;
    sif.issue_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (sif.sif_state != QED_DUP) begin
        done = 1;
        break;
      end
      chk("dup_valid", sif.issue_valid, 1);
      chk("dup_is_dup", sif.issue_is_dup, 1);
      chk("dup_fetch_ready", sif.fetch_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dup_extra: got %0h expected none",
                 sif.issue_insn);
      end else begin
        chk("dup_insn", sif.issue_insn, exp_q.pop_front());
      end
      tick();
    end
    sif.issue_ready = 1'b0;
    chk("drain_in_time", done, 1);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'h00500093, 1'b1, 1'b1, 1'b1, 32'h00500093};
    vecs[1] = '{1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h12345678};
    vecs[3] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000};

    // reset: outputs forced low even with live inputs
    clr();
    resetn = 1'b0;
    sif.fetch_valid = 1'b1;
    sif.issue_ready = 1'b1;
    sif.fetch_insn  = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_valid", sif.issue_valid, 0);
    chk("rst_fetch_ready", sif.fetch_ready, 0);
    chk("rst_issue_insn", sif.issue_insn, 0);
    chk("rst_state", sif.sif_state, QED_IDLE);
    chk("rst_num_orig", sif.qed_num_orig, 0);
    chk("rst_num_dup", sif.qed_num_dup, 0);
    chk("rst_qed_ready", sif.qed_ready, 0);
    clr();
    resetn = 1'b1;
    tick();

    // IDLE passthrough table
    for (int i = 0; i < 4; i++) begin
      sif.fetch_valid = vecs[i].fv;
      sif.fetch_insn  = vecs[i].insn;
      sif.issue_ready = vecs[i].ir;
      #1;
      chk("idle_issue_valid", sif.issue_valid, vecs[i].exp_iv);
      chk("idle_fetch_ready", sif.fetch_ready, vecs[i].exp_fr);
      chk("idle_issue_insn", sif.issue_insn, vecs[i].exp_insn);
      chk("idle_is_dup", sif.issue_is_dup, 0);
      chk("idle_state", sif.sif_state, QED_IDLE);
      tick();
    end
    clr();

    // basic orig/dup round trip
    sif.qed_ena = 1'b1;
    tick();
    chk("enter_orig", sif.sif_state, QED_ORIG);
    sif.orig_retire = 1'b1;
    orig_push(32'h00500093);
    orig_push(32'h00A00113);
    sif.orig_retire = 1'b0;
    to_dup();
    #1;
    chk("hold_valid", sif.issue_valid, 1);
    chk("hold_insn0", sif.issue_insn, 32'h00500093);
    tick();
    chk("hold_insn1", sif.issue_insn, 32'h00500093);
    chk("hold_state", sif.sif_state, QED_DUP);
    drain(8);
    #1;
    chk("wait_state", sif.sif_state, QED_WAIT);
    chk("wait_no_rdy", sif.qed_ready, 0);
    chk("wait_issue_valid", sif.issue_valid, 0);
    sif.dup_retire = 1'b1;
    tick();
    tick();
    sif.dup_retire = 1'b0;
    #1;
    chk("rt_num_orig", sif.qed_num_orig, 2);
    chk("rt_num_dup", sif.qed_num_dup, 2);
    chk("rt_qed_ready", sif.qed_ready, 1);
    tick();
    chk("rt_back_orig", sif.sif_state, QED_ORIG);
    chk("rt_pulse_end", sif.qed_ready, 0);

    // exec_dup ignored with empty cache
    sif.exec_dup = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ed_empty_state", sif.sif_state, QED_ORIG);
      chk("ed_empty_is_dup", sif.issue_is_dup, 0);
      tick();
    end
    sif.exec_dup = 1'b0;

    // fill the cache
    for (int i = 0; i < 16; i++)
      orig_push(32'h1000_0000 + 32'(i));
`ifdef QED_AUTO_SWITCH_EN
    #1;
    chk("full_auto_dup", sif.sif_state, QED_DUP);
`else
    sif.fetch_valid = 1'b1;
    sif.fetch_insn  = 32'hBAD0BAD0;
    sif.issue_ready = 1'b1;
    #1;
    chk("full_fetch_ready", sif.fetch_ready, 0);
    chk("full_issue_valid", sif.issue_valid, 0);
    chk("full_state", sif.sif_state, QED_ORIG);
    tick();
    chk("full_fetch_ready2", sif.fetch_ready, 0);
    sif.fetch_valid = 1'b0;
    sif.issue_ready = 1'b0;
    to_dup();
`endif
    drain(40);
    #1;
    chk("full_wait_rdy", sif.qed_ready, 1);
    chk("full_wait_state", sif.sif_state, QED_WAIT);
    tick();
    chk("full_back_orig", sif.sif_state, QED_ORIG);

    // simultaneous retires in WAIT
    sif.orig_retire = 1'b1;
    sif.dup_retire  = 1'b1;
    tick();
    tick();
    sif.dup_retire = 1'b0;
    tick();
    sif.orig_retire = 1'b0;
    orig_push(32'h00000013);
    to_dup();
    drain(8);
    #1;
    chk("w5_state", sif.sif_state, QED_WAIT);
    chk("w5_num_orig", sif.qed_num_orig, 5);
    chk("w5_num_dup", sif.qed_num_dup, 4);
    chk("w5_no_rdy", sif.qed_ready, 0);
    sif.orig_retire = 1'b1;
    sif.dup_retire  = 1'b1;
    tick();
    sif.orig_retire = 1'b0;
    sif.dup_retire  = 1'b0;
    #1;
    chk("w6_num_orig", sif.qed_num_orig, 6);
    chk("w6_num_dup", sif.qed_num_dup, 5);
    chk("w6_no_rdy", sif.qed_ready, 0);
    chk("w6_state", sif.sif_state, QED_WAIT);
    sif.dup_retire = 1'b1;
    tick();
    sif.dup_retire = 1'b0;
    #1;
    chk("w6_num_dup2", sif.qed_num_dup, 6);
    chk("w6_rdy", sif.qed_ready, 1);
    tick();
    chk("w6_back_orig", sif.sif_state, QED_ORIG);

    // counter wrap
    sif.orig_retire = 1'b1;
    sif.dup_retire  = 1'b1;
    repeat (65535 - 6) tick();
    sif.orig_retire = 1'b0;
    sif.dup_retire  = 1'b0;
    #1;
    chk("wr_orig_max", sif.qed_num_orig, 32'hFFFF);
    chk("wr_dup_max", sif.qed_num_dup, 32'hFFFF);
    sif.orig_retire = 1'b1;
    tick();
    sif.orig_retire = 1'b0;
    #1;
    chk("wr_orig_zero", sif.qed_num_orig, 0);
    chk("wr_dup_still", sif.qed_num_dup, 32'hFFFF);
    orig_push(32'h33333333);
    to_dup();
    drain(8);
    #1;
    chk("wr_wait_no_rdy", sif.qed_ready, 0);
    sif.dup_retire = 1'b1;
    tick();
    sif.dup_retire = 1'b0;
    #1;
    chk("wr_dup_zero", sif.qed_num_dup, 0);
    chk("wr_rdy", sif.qed_ready, 1);
    tick();
    chk("wr_back_orig", sif.sif_state, QED_ORIG);

    // async reset mid-DUP with 3 cached entries
    sif.orig_retire = 1'b1;
    tick();
    sif.orig_retire = 1'b0;
    orig_push(32'hA0000001);
    orig_push(32'hA0000002);
    orig_push(32'hA0000003);
    to_dup();
    sif.issue_ready = 1'b0;
    tick();
    chk("pre_rst_state", sif.sif_state, QED_DUP);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_state", sif.sif_state, QED_IDLE);
    chk("arst_issue_valid", sif.issue_valid, 0);
    chk("arst_num_orig", sif.qed_num_orig, 0);
    chk("arst_qed_ready", sif.qed_ready, 0);
    tick();
    chk("rst2_state", sif.sif_state, QED_IDLE);
    chk("rst2_num_dup", sif.qed_num_dup, 0);
    chk("rst2_is_dup", sif.issue_is_dup, 0);
    exp_q.delete();
    resetn = 1'b1;
    sif.qed_ena = 1'b1;
    tick();
    chk("post_rst_orig", sif.sif_state, QED_ORIG);
    sif.exec_dup = 1'b1;
    tick();
    tick();
    sif.exec_dup = 1'b0;
    #1;
    chk("post_rst_empty", sif.sif_state, QED_ORIG);
    chk("post_rst_is_dup", sif.issue_is_dup, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
